// File: rtl/main_memory_responder.sv
// Word-addressed main-memory slave: captures one RD/WR strobe, waits WAIT_STATES
// cycles, performs the access and returns a single-cycle ACK (plus Error if illegal).
module main_memory_responder #(
    parameter int DATAWIDTH_BUS      = 32,
    parameter int DATAWIDTH_MEMINDEX = 10,
    parameter int WAIT_STATES        = 2
) (
    input  logic                     MAIN_MEMORY_CLOCK_50,
    input  logic                     MAIN_MEMORY_ResetInLow_In,
    input  logic                     MAIN_MEMORY_RD_In,
    input  logic                     MAIN_MEMORY_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_Address_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_Data_InBus,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_Data_OutBus,
    output logic                     MAIN_MEMORY_ACK_Out,
    output logic                     MAIN_MEMORY_Error_Out
);

    localparam int DEPTH = 1 << DATAWIDTH_MEMINDEX;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

    state_t                          state_q;
    logic [3:0]                      cnt_q;
    logic [DATAWIDTH_BUS-1:0]        addr_q;
    logic [DATAWIDTH_BUS-1:0]        wdata_q;
    logic [DATAWIDTH_BUS-1:0]        rdata_q;
    logic                            wr_q;
    logic                            ack_q;
    logic                            err_q;

    logic [DATAWIDTH_BUS-1:0]        mem [DEPTH];
    logic [DATAWIDTH_MEMINDEX-1:0]   idx;
    logic                            legal;
    logic                            access;

    assign idx    = addr_q[DATAWIDTH_MEMINDEX+1:2];
    assign legal  = (addr_q[1:0] == 2'b00) &&
                    (addr_q[DATAWIDTH_BUS-1:DATAWIDTH_MEMINDEX+2] == '0);
    assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Array write is gated by reset so an edge coinciding with reset never commits.
    always_ff @(posedge MAIN_MEMORY_CLOCK_50) begin
        if (MAIN_MEMORY_ResetInLow_In && access && wr_q && legal)
            mem[idx] <= wdata_q;
    end

    always_ff @(posedge MAIN_MEMORY_CLOCK_50 or negedge MAIN_MEMORY_ResetInLow_In) begin
        if (!MAIN_MEMORY_ResetInLow_In) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MAIN_MEMORY_RD_In ^ MAIN_MEMORY_WR_In) begin
                        addr_q  <= MAIN_MEMORY_Address_InBus;
                        wdata_q <= MAIN_MEMORY_Data_InBus;
                        wr_q    <= MAIN_MEMORY_WR_In;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= S_WAIT;
                    end else if (MAIN_MEMORY_RD_In && MAIN_MEMORY_WR_In) begin
                        // Conflicting strobes: no access, report straight away.
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ack_q   <= 1'b1;
                        err_q   <= !legal;
                        state_q <= S_DONE;
                        if (!wr_q)
                            rdata_q <= legal ? mem[idx] : '0;
                    end
                end
                S_DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Wait for the strobe to drop so a held request is serviced once.
                    if (!MAIN_MEMORY_RD_In && !MAIN_MEMORY_WR_In)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MAIN_MEMORY_Data_OutBus = rdata_q;
    assign MAIN_MEMORY_ACK_Out     = ack_q;
    assign MAIN_MEMORY_Error_Out   = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
module tb_main_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        ack  [2];
    logic        err  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_memory_responder #(.DATAWIDTH_BUS(32), .DATAWIDTH_MEMINDEX(10), .WAIT_STATES(2)) u_ws2 (
        .MAIN_MEMORY_CLOCK_50      (clk),
        .MAIN_MEMORY_ResetInLow_In (rst_n),
        .MAIN_MEMORY_RD_In         (rd[0]),
        .MAIN_MEMORY_WR_In         (wr[0]),
        .MAIN_MEMORY_Address_InBus (addr[0]),
        .MAIN_MEMORY_Data_InBus    (din[0]),
        .MAIN_MEMORY_Data_OutBus   (dout[0]),
        .MAIN_MEMORY_ACK_Out       (ack[0]),
        .MAIN_MEMORY_Error_Out     (err[0])
    );

    main_memory_responder #(.DATAWIDTH_BUS(32), .DATAWIDTH_MEMINDEX(10), .WAIT_STATES(0)) u_ws0 (
        .MAIN_MEMORY_CLOCK_50      (clk),
        .MAIN_MEMORY_ResetInLow_In (rst_n),
        .MAIN_MEMORY_RD_In         (rd[1]),
        .MAIN_MEMORY_WR_In         (wr[1]),
        .MAIN_MEMORY_Address_InBus (addr[1]),
        .MAIN_MEMORY_Data_InBus    (din[1]),
        .MAIN_MEMORY_Data_OutBus   (dout[1]),
        .MAIN_MEMORY_ACK_Out       (ack[1]),
        .MAIN_MEMORY_Error_Out     (err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Holds the request for `hold` cycles, then drops it and
    // watches three more cycles. k=1 is the cycle after the capture edge.
    task automatic req(input int s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input int hold,
                       output int first_k, output int nack, output int ecoin,
                       output int eoth, output logic [31:0] dack);
        first_k = 0; nack = 0; ecoin = 0; eoth = 0; dack = '0;
        rd[s] = r; wr[s] = w; addr[s] = a; din[s] = d;
        for (int k = 1; k <= hold + 3; k++) begin
            @(negedge clk);
            if (ack[s]) begin
                nack++;
                if (first_k == 0) first_k = k;
                dack = dout[s];
                if (err[s]) ecoin++;
            end else if (err[s]) begin
                eoth++;
            end
            if (k == hold) begin
                rd[s] = 1'b0; wr[s] = 1'b0;
            end
        end
    endtask

    int fk, na, ec, eo;
    logic [31:0] dk;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_dout", dout[0], 32'h0);
        chk("rst_ack",  {31'h0, ack[0]}, 32'h0);
        chk("rst_err",  {31'h0, err[0]}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0xCAFEF00D to 0x40: ACK three edges after capture.
        req(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 6, fk, na, ec, eo, dk);
        chk("wr40_lat",  32'(fk), 32'd4);
        chk("wr40_nack", 32'(na), 32'd1);
        chk("wr40_err",  32'(ec + eo), 32'd0);
        chk("wr40_dout", dout[0], 32'h0);

        // Read held for 10 cycles: one ACK only.
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 10, fk, na, ec, eo, dk);
        chk("rd40_lat",  32'(fk), 32'd4);
        chk("rd40_nack", 32'(na), 32'd1);
        chk("rd40_data", dk, 32'hCAFEF00D);
        chk("rd40_err",  32'(ec + eo), 32'd0);

        // After release, a new request is accepted again.
        req(0, 1'b0, 1'b1, 32'h10, 32'h11111111, 6, fk, na, ec, eo, dk);
        chk("wr10_lat",  32'(fk), 32'd4);
        chk("hold_dout", dout[0], 32'hCAFEF00D);
        req(0, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 6, fk, na, ec, eo, dk);
        chk("wr0_nack",  32'(na), 32'd1);

        // Misaligned read.
        req(0, 1'b1, 1'b0, 32'h42, 32'h0, 6, fk, na, ec, eo, dk);
        chk("mis_nack", 32'(na), 32'd1);
        chk("mis_err",  32'(ec), 32'd1);
        chk("mis_eoth", 32'(eo), 32'd0);
        chk("mis_data", dout[0], 32'h0);

        // Out-of-range write aliases onto word 0 if the range check is missing.
        req(0, 1'b0, 1'b1, 32'h1000, 32'h55555555, 6, fk, na, ec, eo, dk);
        chk("oor_nack", 32'(na), 32'd1);
        chk("oor_err",  32'(ec), 32'd1);
        chk("oor_eoth", 32'(eo), 32'd0);
        req(0, 1'b1, 1'b0, 32'h0, 32'h0, 6, fk, na, ec, eo, dk);
        chk("w0_keep",  dk, 32'hA5A5A5A5);

        // Both strobes high: error, no write, read data unchanged.
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 6, fk, na, ec, eo, dk);
        chk("pre_both", dk, 32'hCAFEF00D);
        req(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 6, fk, na, ec, eo, dk);
        chk("both_nack", 32'(na), 32'd1);
        chk("both_err",  32'(ec), 32'd1);
        chk("both_eoth", 32'(eo), 32'd0);
        chk("both_dout", dout[0], 32'hCAFEF00D);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 6, fk, na, ec, eo, dk);
        chk("both_mem",  dk, 32'hCAFEF00D);

        // Reset mid-WAIT of a write: aborts, outputs clear immediately.
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h10; din[0] = 32'hDEADBEEF;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0; wr[0] = 1'b0;
        #1;
        chk("arst_dout", dout[0], 32'h0);
        chk("arst_ack",  {31'h0, ack[0]}, 32'h0);
        chk("arst_err",  {31'h0, err[0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 6, fk, na, ec, eo, dk);
        chk("arst_idle", 32'(fk), 32'd4);
        chk("arst_mem",  dk, 32'h11111111);

        // WAIT_STATES=0: ACK in the cycle after the edge following capture.
        req(1, 1'b0, 1'b1, 32'h0, 32'h1, 4, fk, na, ec, eo, dk);
        chk("ws0_wr_lat",  32'(fk), 32'd2);
        chk("ws0_wr_nack", 32'(na), 32'd1);
        req(1, 1'b1, 1'b0, 32'h0, 32'h0, 4, fk, na, ec, eo, dk);
        chk("ws0_rd_lat",  32'(fk), 32'd2);
        chk("ws0_rd_data", dk, 32'h00000001);
        chk("ws0_rd_err",  32'(ec + eo), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
